// File: rtl/mux_rr_sched_pkg.sv
// -----------------------------------------------------------------------------
// mux_sched_pkg
//   Shared defaults, FSM state type and helpers for the round-robin mux
//   scheduler (mux_rr_sched) and its rotate-priority picker (mux_rr_pick).
//   Optional feature macro used by the scheduler: MUX_SCHED_BURST_EN.
// -----------------------------------------------------------------------------
package mux_sched_pkg;

  localparam int unsigned N_REQ_DEF = 31;
  localparam int unsigned SEL_W_DEF = 5;
  localparam int unsigned SEL_MAX   = N_REQ_DEF - 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Width of a counter that must reach max_burst inclusive.
  function automatic int unsigned burst_cnt_w(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mux_rr_sched_if.sv
// -----------------------------------------------------------------------------
// mux_sched_if
//   Request / select / handshake bundle between the scheduler and the
//   requesters plus the downstream consumer of the mux output.
//   req       : per-requester request level
//   out_ready : downstream accepts the current beat
//   sel       : registered mux select
//   out_valid : mux output holds a valid beat
//   gnt       : one-hot of sel while out_valid
//   ack       : one-cycle pulse on bit sel in the transfer cycle
//   master = scheduler side, slave = requester/consumer side.
// -----------------------------------------------------------------------------
interface mux_sched_if #(
  parameter int unsigned N_REQ = 31,
  parameter int unsigned SEL_W = 5
) ();

  logic [N_REQ-1:0] req;
  logic             out_ready;
  logic [SEL_W-1:0] sel;
  logic             out_valid;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] ack;

  modport master (
    input  req,
    input  out_ready,
    output sel,
    output out_valid,
    output gnt,
    output ack
  );

  modport slave (
    output req,
    output out_ready,
    input  sel,
    input  out_valid,
    input  gnt,
    input  ack
  );

endinterface

// File: rtl/mux_rr_pick.sv
// -----------------------------------------------------------------------------
// mux_rr_pick
//   Purely combinational rotate-priority finder. Returns the first set bit of
//   req searching ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1 (modulo N_REQ).
//   req   : request vector
//   ptr   : search start index (< N_REQ)
//   found : at least one request set
//   idx   : index of the winner (0 when nothing found)
// -----------------------------------------------------------------------------
module mux_rr_pick
  import mux_sched_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  // One extra bit so ptr + offset never overflows before the modulo fold.
  logic [SEL_W:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (SEL_W+1)'(i);
      if (cand >= (SEL_W+1)'(N_REQ)) begin
        cand = cand - (SEL_W+1)'(N_REQ);
      end
      if (!found && req[cand[SEL_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_rr_sched.sv
// -----------------------------------------------------------------------------
// mux_rr_sched
//   Round-robin scheduler sharing an N_REQ-input mux among N_REQ requesters.
//   Drives the registered mux select, a valid/ready handshake towards the
//   consumer, and per-requester grant / acknowledge.
//   clk   : clock, all state on rising edge
//   reset : synchronous, active-high
//   bus   : mux_sched_if.master (req, out_ready, sel, out_valid, gnt, ack)
//   Optional: MUX_SCHED_BURST_EN lets a requester keep the grant for up to
//   MAX_BURST consecutive beats while it keeps requesting.
// -----------------------------------------------------------------------------
module mux_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int unsigned N_REQ     = N_REQ_DEF,
  parameter int unsigned SEL_W     = SEL_W_DEF,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  mux_sched_if.master  bus
);

  if (MAX_BURST == 0) begin : g_bad_burst
    $error("mux_rr_sched: MAX_BURST must be at least 1");
  end

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;

  logic             xfer;
  logic             keep;
  logic [SEL_W-1:0] sel_inc;
  logic [N_REQ-1:0] pick_req;
  logic [SEL_W-1:0] pick_ptr;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic [N_REQ-1:0] gnt_c;

  assign xfer    = (state_q == BUSY) && bus.out_ready;
  assign sel_inc = (sel_q == SEL_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;

  // In the transfer cycle the search already starts after the current owner
  // and excludes it, so the next grant is ready at the same edge (no bubble).
  always_comb begin
    pick_req = bus.req;
    pick_ptr = ptr_q;
    if (xfer) begin
      pick_req[sel_q] = 1'b0;
      pick_ptr        = sel_inc;
    end
  end

  mux_rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef MUX_SCHED_BURST_EN
  localparam int unsigned CNT_W = burst_cnt_w(MAX_BURST);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign keep = xfer && bus.req[sel_q] && (cnt_q < CNT_W'(MAX_BURST));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (pick_found) cnt_d = CNT_W'(1);
    end else if (xfer) begin
      if (keep)            cnt_d = cnt_q + 1'b1;
      else if (pick_found) cnt_d = CNT_W'(1);
      else                 cnt_d = '0;
    end
  end
`else
  assign keep = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          sel_d   = pick_idx;
        end
      end
      BUSY: begin
        if (xfer && !keep) begin
          ptr_d = sel_inc;
          if (pick_found) begin
            sel_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      gnt_c[i] = (state_q == BUSY) && (sel_q == SEL_W'(i));
    end
  end

  assign bus.sel       = sel_q;
  assign bus.out_valid = (state_q == BUSY);
  assign bus.gnt       = gnt_c;
  assign bus.ack       = gnt_c & {N_REQ{bus.out_ready}};

endmodule
